// File: rtl/score_arbiter.sv
// score_arbiter: queues score events from up to four sources, grants them
// round-robin and applies each source's fixed BCD amount to a 6-digit score
// through a digit-serial add/subtract datapath with clamping.
//
// state  | meaning
// IDLE   | waiting; grants the next pending source when one exists
// DIGIT  | one BCD digit per cycle into the working register, units first
// COMMIT | working register (or clamp value) is written to the score
module score_arbiter #(
  parameter logic [23:0] AMOUNT0  = 24'h000040,
  parameter logic [23:0] AMOUNT1  = 24'h000100,
  parameter logic [23:0] AMOUNT2  = 24'h000010,
  parameter logic [23:0] AMOUNT3  = 24'h000050,
  parameter logic [3:0]  SUB_MASK = 4'b1000
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [3:0]  req,
  input  logic        clearScore,
  output logic [23:0] score,
  output logic [23:0] scoreDisplay,
  output logic        scoreUpdate,
  output logic        busy,
  output logic        eventLost
);

  typedef enum logic [1:0] {IDLE, DIGIT, COMMIT} state_e;

  state_e      state_q;
  logic [1:0]  pend_q [4];
  logic [1:0]  ptr_q;
  logic [23:0] op_q;
  logic [23:0] work_q;
  logic [23:0] score_q;
  logic [23:0] disp_q;
  logic        sub_q;
  logic        cb_q;
  logic [2:0]  idx_q;
  logic        lost_q;

  logic        gnt_vld;
  logic [1:0]  gnt_idx;
  logic [1:0]  cand;
  logic [23:0] gnt_amt;
  logic        gnt_sub;

  logic [3:0]  s_dig;
  logic [3:0]  o_dig;
  logic [3:0]  w_dig;
  logic [4:0]  sum;
  logic [4:0] sum_adj;
  logic [4:0]  dif;
  logic [4:0]  dif_adj;
  logic        cb_d;

  // Round-robin search: scan from the far end back so the first nonzero
  // counter at or after the pointer is the last one to win.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    cand    = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + k[1:0];
      if (pend_q[cand] != 2'd0) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (state_q != IDLE) gnt_vld = 1'b0;
  end

  // Operand and operation of the granted source.
  always_comb begin
    gnt_amt = AMOUNT0;
    case (gnt_idx)
      2'd0: gnt_amt = AMOUNT0;
      2'd1: gnt_amt = AMOUNT1;
      2'd2: gnt_amt = AMOUNT2;
      default: gnt_amt = AMOUNT3;
    endcase
    gnt_sub = SUB_MASK[gnt_idx];
  end

  // One BCD digit of add or subtract; cb_q is the carry or the borrow
  // depending on the latched operation.
  always_comb begin
    s_dig   = score_q[{idx_q, 2'b00} +: 4];
    o_dig   = op_q[{idx_q, 2'b00} +: 4];
    sum     = {1'b0, s_dig} + {1'b0, o_dig} + {4'b0000, cb_q};
    sum_adj = sum - 5'd10;
    dif     = {1'b0, s_dig} - {1'b0, o_dig} - {4'b0000, cb_q};
    dif_adj = dif + 5'd10;
    w_dig   = sum[3:0];
    cb_d    = 1'b0;
    if (sub_q) begin
      if (dif[4]) begin
        w_dig = dif_adj[3:0];
        cb_d  = 1'b1;
      end else begin
        w_dig = dif[3:0];
      end
    end else if (sum > 5'd9) begin
      w_dig = sum_adj[3:0];
      cb_d  = 1'b1;
    end
  end

  // Sequencer, pending counters, score and display registers.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= IDLE;
      for (int i = 0; i < 4; i++) pend_q[i] <= 2'd0;
      ptr_q   <= 2'd0;
      op_q    <= '0;
      work_q  <= '0;
      score_q <= '0;
      disp_q  <= '0;
      sub_q   <= 1'b0;
      cb_q    <= 1'b0;
      idx_q   <= 3'd0;
      lost_q  <= 1'b0;
    end else if (clearScore) begin
      state_q <= IDLE;
      for (int i = 0; i < 4; i++) pend_q[i] <= 2'd0;
      score_q <= '0;
      disp_q  <= '0;
    end else begin
      if (startOfFrame) disp_q <= score_q;

      for (int i = 0; i < 4; i++) begin
        if (req[i] && !(gnt_vld && gnt_idx == 2'(i))) begin
          if (pend_q[i] == 2'd3) lost_q <= 1'b1;
          else                   pend_q[i] <= pend_q[i] + 2'd1;
        end else if (!req[i] && gnt_vld && gnt_idx == 2'(i)) begin
          pend_q[i] <= pend_q[i] - 2'd1;
        end
      end

      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            ptr_q   <= gnt_idx + 2'd1;
            op_q    <= gnt_amt;
            sub_q   <= gnt_sub;
            idx_q   <= 3'd0;
            cb_q    <= 1'b0;
            state_q <= DIGIT;
          end
        end
        DIGIT: begin
          work_q[{idx_q, 2'b00} +: 4] <= w_dig;
          cb_q  <= cb_d;
          idx_q <= idx_q + 3'd1;
          if (idx_q == 3'd5) state_q <= COMMIT;
        end
        default: begin
          if (cb_q) score_q <= sub_q ? 24'h000000 : 24'h999999;
          else      score_q <= work_q;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign score        = score_q;
  assign scoreDisplay = disp_q;
  assign scoreUpdate  = (state_q == COMMIT);
  assign busy         = (state_q != IDLE);
  assign eventLost    = lost_q;

endmodule

// File: doc/score_arbiter.md
# score_arbiter

Serializes score-change events from the collision logic into a single 6-digit BCD score register. Up to four event sources, such as shot/enemy hits and tower/player collisions, raise single-cycle request pulses. The block queues the requests per source, grants them round-robin, and applies each source's fixed BCD amount through one digit-serial add/subtract datapath with clamping. A frame-synchronous snapshot of the score feeds the score display.

## Interface
Parameters:
- AMOUNT0, 24'h000040: BCD amount for source 0.
- AMOUNT1, 24'h000100: BCD amount for source 1.
- AMOUNT2, 24'h000010: BCD amount for source 2.
- AMOUNT3, 24'h000050: BCD amount for source 3.
- SUB_MASK, 4'b1000: bit i = 1 means source i subtracts; otherwise it adds.

Ports:
- clk  in  1  system clock; the only clock.
- resetN  in  1  reset; synchronous and active-low.
- startOfFrame  in  1  one-cycle pulse at the start of every frame.
- req  in  4  one-cycle event pulses, one bit per source.
- clearScore  in  1  synchronous clear of the score and all pending events.
- score  out  24  live BCD score, 6 digits, [3:0] = units.
- scoreDisplay  out  24  copy of score latched on startOfFrame.
- scoreUpdate  out  1  one-cycle pulse in the COMMIT cycle.
- busy  out  1  high when state is not IDLE.
- eventLost  out  1  sticky flag: a request was dropped.

## Operation
- Reset values: all outputs 0, state IDLE, pending counters 0, round-robin pointer 0.
- Pending counters:
  - One 2-bit saturating counter per source.
  - req[i] increments counter i.
  - A request arriving while counter i = 3 is dropped and sets eventLost.
  - If req[i] and a grant of i fall in the same cycle, the counter is unchanged.
- Arbitration: in IDLE, if any counter is nonzero, grant the first nonzero source searching upward from the pointer (mod 4). Then:
  - pointer := granted + 1 (mod 4);
  - decrement that counter;
  - latch the operand AMOUNTi and the op SUB_MASK[i];
  - clear the digit index, carry and borrow;
  - go to DIGIT.
- DIGIT, 6 cycles, index 0..5, units digit first:
  - Add: s = score digit + operand digit + carry. If s > 9, write s - 10 and set carry = 1; otherwise write s and set carry = 0.
  - Subtract: d = score digit - operand digit - borrow. If d < 0, write d + 10 and set borrow = 1; otherwise write d and set borrow = 0.
  - Results go to a working register; score itself is untouched during DIGIT.
  - After index 5, go to COMMIT.
- COMMIT, 1 cycle:
  - score := working register, except after a final carry score := 24'h999999, and after a final borrow score := 0.
  - Pulse scoreUpdate, then go to IDLE.
- scoreDisplay := score on every startOfFrame. If startOfFrame coincides with COMMIT, the pre-commit value is captured.
- clearScore takes priority over everything except reset:
  - score, scoreDisplay and all pending counters go to 0;
  - any in-flight operation is aborted with no scoreUpdate;
  - state goes to IDLE;
  - the pointer and eventLost are kept.
  - req bits in the same cycle as clearScore are discarded.
- resetN low at any cycle, including mid-DIGIT, forces all reset values at the next edge.
- Operand digits are assumed valid BCD, set by parameter; no check is made.

## Timing
- The req pulse in cycle 0 is counted at the end of cycle 0.
- Cycle 1: IDLE grants. Cycles 2-7: DIGIT 0..5. Cycle 8: COMMIT, scoreUpdate = 1.
- New score is visible from cycle 9.
- Throughput is one event per 8 cycles (IDLE, 6×DIGIT, COMMIT); requests arriving meanwhile queue in the pending counters.
- busy is high in cycles 2-8; it is low in the granting IDLE cycle.

## Test plan
- Reset, then req = 4'b0001 in cycle 0 -> scoreUpdate in cycle 8; score = 24'h000040 from cycle 9; scoreDisplay still 0 until the next startOfFrame, then 24'h000040.
- 25 spaced req[0] pulses -> after the 24th, score = 24'h000960; after the 25th, score = 24'h001000 (carry ripples through digits 1-3).
- req = 4'b1111 in one cycle from reset -> commits in order 0, 1, 2, 3 at cycles 8, 16, 24, 32. Intermediate scores are 000040, 000140, 000150; final score is 24'h000100.
- Score 0, then req[3] -> final borrow; score stays 24'h000000 and scoreUpdate still pulses.
- Five req[1] pulses during a busy period -> eventLost = 1; exactly 3 further source-1 commits occur (+300 BCD).
- clearScore in cycle 4 of an operation -> next cycle: score = 0, busy = 0, all pending 0, no scoreUpdate for the aborted event. resetN low during DIGIT -> all outputs 0 at the next edge.
